// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of a 5-stage RISC-V pipeline.
// Owns the PC and keeps at most one imem request outstanding.
// Fills a single output slot (InstrF/PCF/PCPlus4F/ValidF) feeding IF/ID.
// A redirect from EX wins over everything else: it empties the slot,
// reloads the PC and, if a response is still in flight, marks it for drop.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_d,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        ValidF
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic        r_drop;
   logic        w_drop_nxt;

   logic [31:0] r_instr;
   logic [31:0] r_pcf;
   logic [31:0] r_pcp4;
   logic        r_valid;

   logic        w_consume;
   logic        w_slot_free;
   logic        w_issue;
   logic        w_accept;
   logic        w_rsp;
   logic        w_load;
   logic [31:0] w_redir_pc;
   logic [31:0] w_pc_plus4;

   // Handshake qualifiers shared by the FSM, PC and output slot.
   // A request may only go out when the slot will be empty after this edge,
   // so a response can never arrive with nowhere to land.
   always_comb begin
      w_consume   = r_valid & ~stall_d;
      w_slot_free = ~r_valid | w_consume;
      w_issue     = (r_state == S_REQ) & w_slot_free;
      w_accept    = w_issue & imem_req_ready;
      w_rsp       = (r_state == S_WAIT) & imem_rsp_valid;
      // Responses are only used in WAIT; a same-cycle redirect or a pending
      // drop turns a response into a discard.
      w_load      = w_rsp & ~r_drop & ~redirect;
      w_redir_pc  = redirect_pc & ~32'd3;
      w_pc_plus4  = r_pc + 32'd4;
   end

   // Next-state and drop-flag logic.
   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop;
      unique case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (w_accept) begin
               w_state_nxt = S_WAIT;
               // Accepted with the old address while being redirected:
               // the coming response belongs to the wrong path.
               w_drop_nxt  = redirect;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               // Response consumed (loaded or discarded); nothing in flight.
               w_state_nxt = S_REQ;
               w_drop_nxt  = 1'b0;
            end else if (redirect) begin
               w_drop_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_drop_nxt  = 1'b0;
         end
      endcase
   end

   // Next PC: redirect target, else advance on each accepted instruction.
   always_comb begin
      w_pc_nxt = r_pc;
      if (redirect) begin
         w_pc_nxt = w_redir_pc;
      end else if (w_load) begin
         w_pc_nxt = w_pc_plus4;
      end
   end

   // FSM state, PC and drop flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Output slot: redirect empties it, a load fills it, a consume empties it.
   // A load on the same edge as a consume overwrites the consumed entry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_instr <= 32'd0;
         r_pcf   <= 32'd0;
         r_pcp4  <= 32'd0;
      end else if (redirect) begin
         r_valid <= 1'b0;
         r_instr <= 32'd0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_instr <= imem_rsp_data;
         r_pcf   <= r_pc;
         r_pcp4  <= w_pc_plus4;
      end else if (w_consume) begin
         r_valid <= 1'b0;
         r_instr <= 32'd0;
      end
   end

   // imem address tracks the PC directly, so a redirect while a request is
   // waiting for ready changes the address on the following cycle.
   assign imem_req_valid = w_issue;
   assign imem_req_addr  = r_pc;

   assign InstrF   = r_instr;
   assign PCF      = r_pcf;
   assign PCPlus4F = r_pcp4;
   assign ValidF   = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with an imem responder
// and an architectural reference model (expected next PC of the consumed
// instruction stream). A negedge monitor compares every consumed slot.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clock;
   logic        reset;
   logic        stall_d;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        ValidF;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clock         (clock),
      .reset         (reset),
      .stall_d       (stall_d),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .InstrF        (InstrF),
      .PCF           (PCF),
      .PCPlus4F      (PCPlus4F),
      .ValidF        (ValidF)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      int          lat;
   } pend_t;

   pend_t       pend_q[$];
   int          checks = 0;
   int          errors = 0;
   int          consumed = 0;
   int          idle_cyc = 0;
   int          lat_min = 0;
   int          lat_max = 0;
   bit          mon_en = 0;
   bit          imem_auto = 0;
   bit          prev_hold = 0;
   bit          prev_wait = 0;
   logic [31:0] prev_addr = 32'd0;
   logic [31:0] exp_pc = RST_PC;

   // imem contents: a fixed scramble of the address.
   function automatic logic [31:0] f_instr(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rand_tgt();
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(7, 0) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor/scoreboard: invariants, request address, consumed instructions.
   always @(negedge clock) begin
      if (mon_en && reset) begin
         if (!ValidF) chk("instr_zero_when_invalid", InstrF, 32'd0);
         if (ValidF && stall_d) chk("no_req_when_slot_full", {31'd0, imem_req_valid}, 32'd0);
         if (prev_hold) begin
            chk("stall_hold_valid", {31'd0, ValidF}, 32'd1);
            chk("stall_hold_pcf", PCF, exp_pc);
            chk("stall_hold_instr", InstrF, f_instr(exp_pc));
         end
         if (prev_wait) chk("addr_hold_not_ready", imem_req_addr, prev_addr);
         prev_hold = ValidF && stall_d && !redirect;
         prev_wait = imem_req_valid && !imem_req_ready && !redirect;
         prev_addr = imem_req_addr;

         if (imem_req_valid && imem_req_ready) begin
            if (!redirect) chk("req_addr", imem_req_addr, ValidF ? exp_pc + 32'd4 : exp_pc);
            if (imem_auto)
               pend_q.push_back('{addr: imem_req_addr,
                                  lat: int'($urandom_range(lat_max, lat_min))});
         end

         if (ValidF && !stall_d && !redirect) begin
            chk("out_pcf", PCF, exp_pc);
            chk("out_pcplus4", PCPlus4F, exp_pc + 32'd4);
            chk("out_instr", InstrF, f_instr(exp_pc));
            exp_pc   = exp_pc + 32'd4;
            consumed++;
            idle_cyc = 0;
         end else begin
            idle_cyc++;
         end
         if (redirect) exp_pc = redirect_pc & ~32'd3;

         if (idle_cyc > 200) begin
            checks++;
            errors++;
            $display("FAIL watchdog: no instruction consumed for %0d cycles, required progress", idle_cyc);
            idle_cyc = 0;
         end
      end
   end

   // One clock of stimulus; imem responder runs here as well.
   task automatic cycle(input int ps, input int pr, input int prdy,
                        input bit use_t, input logic [31:0] tgt,
                        input bit r_on_rsp, input bit r_on_req);
      @(posedge clock);
      #1;
      stall_d        = (int'($urandom_range(99, 0)) < ps);
      imem_req_ready = (int'($urandom_range(99, 0)) < prdy);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (imem_auto && pend_q.size() > 0) begin
         if (pend_q[0].lat == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = f_instr(pend_q[0].addr);
            void'(pend_q.pop_front());
         end else begin
            pend_q[0].lat = pend_q[0].lat - 1;
         end
      end
      #1;
      redirect    = (int'($urandom_range(99, 0)) < pr) ||
                    (r_on_rsp && imem_rsp_valid) ||
                    (r_on_req && imem_req_valid && imem_req_ready);
      redirect_pc = use_t ? tgt : rand_tgt();
   endtask

   task automatic run(input int n, input int ps, input int pr, input int prdy);
      for (int i = 0; i < n; i++) cycle(ps, pr, prdy, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_validf", {31'd0, ValidF}, 32'd0);
      chk("rst_instrf", InstrF, 32'd0);
      chk("rst_pcf", PCF, 32'd0);
      chk("rst_pcplus4f", PCPlus4F, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, RST_PC);
   endtask

   // Bring DUT out of reset at posedge+1 and resync the model.
   task automatic release_reset();
      @(posedge clock);
      #1;
      reset     = 1'b1;
      exp_pc    = RST_PC;
      prev_hold = 0;
      prev_wait = 0;
      idle_cyc  = 0;
      mon_en    = 1;
   endtask

   task automatic wait_accept(input string nm);
      int n;
      n = 0;
      while (pend_q.size() == 0 && n < 20) begin
         cycle(0, 0, 100, 1'b0, 32'd0, 1'b0, 1'b0);
         n++;
      end
      if (pend_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no request accepted within 20 cycles, required one", nm);
      end
   endtask

   initial begin
      int n;
      int c0;
      reset          = 1'b0;
      stall_d        = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 32'd0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      #12;
      chk_reset_vals();
      repeat (2) @(posedge clock);

      // 1: zero-wait fetch stream from RESET_PC, one instruction per 2 cycles.
      imem_auto = 1;
      lat_min   = 0;
      lat_max   = 0;
      consumed  = 0;
      release_reset();
      run(20, 0, 0, 100);
      chk("throughput_ok", {31'd0, (consumed >= 8 && consumed <= 10)}, 32'd1);

      // 2: stall with a full slot, then release.
      run(5, 100, 0, 100);
      run(10, 0, 0, 100);

      // 3: redirect to a misaligned target while waiting on a slow response.
      lat_min = 3;
      lat_max = 3;
      wait_accept("wait_for_t3");
      cycle(0, 100, 100, 1'b1, 32'h0000_2003, 1'b0, 1'b0);
      lat_min = 0;
      lat_max = 0;
      c0 = consumed;
      run(12, 0, 0, 100);
      chk("t3_progress", {31'd0, (consumed > c0)}, 32'd1);

      // 4a: redirect on the same cycle as a response.
      n = 0;
      do begin
         cycle(0, 0, 100, 1'b1, 32'h0000_3000, 1'b1, 1'b0);
         n++;
      end while (!redirect && n < 20);
      run(10, 0, 0, 100);
      // 4b: redirect on the same cycle as a request accept.
      n = 0;
      do begin
         cycle(0, 0, 100, 1'b1, 32'h0000_3400, 1'b0, 1'b1);
         n++;
      end while (!redirect && n < 20);
      c0 = consumed;
      run(10, 0, 0, 100);
      chk("t4_progress", {31'd0, (consumed > c0)}, 32'd1);

      // 6: reset pulse while a response is outstanding; it arrives late.
      lat_min = 3;
      lat_max = 3;
      wait_accept("wait_for_t6");
      mon_en = 0;
      reset  = 1'b0;
      #1;
      chk_reset_vals();
      @(posedge clock);
      #1;
      imem_rsp_valid = 1'b0;
      redirect       = 1'b0;
      if (pend_q.size() > 0) pend_q[0].lat = 0;
      lat_min = 0;
      lat_max = 0;
      release_reset();
      c0 = consumed;
      run(12, 0, 0, 100);
      chk("t6_progress", {31'd0, (consumed > c0)}, 32'd1);

      // 5: ready held low, then wrap through 0xFFFFFFFC.
      run(4, 0, 0, 0);
      cycle(0, 100, 100, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      c0 = consumed;
      run(12, 0, 0, 100);
      chk("t5_wrap_progress", {31'd0, (consumed > c0 + 2)}, 32'd1);

      // Random phase.
      lat_min = 0;
      lat_max = 2;
      run(4000, 30, 5, 70);
      run(10, 0, 0, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
